// File: rtl/axis_dsp_pkg.sv
// Shared constants, sample type and shift clamp for the AXI-Stream DSP chain
// (boxcar decimator and the shifted single-pole LPF that follows it).
package axis_dsp_pkg;

  localparam int default_inout_width    = 12;
  localparam int default_decimal_width  = default_inout_width - 1;
  localparam int default_max_log2_ratio = 10;

  typedef logic signed [default_inout_width-1:0] sample_t;

  function automatic logic [3:0] clamp_shift(input logic [3:0] shift, input logic [3:0] limit);
    return (shift > limit) ? limit : shift;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry valid/ready holding register; a load in the same cycle as a
// drain wins, so the output is replaced without a bubble.
module axis_out_reg #(
  parameter int width = 12
) (
  input  logic             aclk,
  input  logic             resetn,
  input  logic             ld,
  input  logic [width-1:0] ld_data,
  input  logic             ld_last,
  output logic [width-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready
);

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (ld) begin
      m_axis_tdata  <= ld_data;
      m_axis_tlast  <= ld_last;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_boxcar_decimator.sv
// Boxcar decimator: averages blocks of 2^N beats into one output sample.
// Macro ROUND_EN selects round-half-up with positive clamp instead of truncation.
module axis_boxcar_decimator
  import axis_dsp_pkg::*;
#(
  parameter int inout_width    = default_inout_width,
  parameter int max_log2_ratio = default_max_log2_ratio,
  localparam int acc_width     = inout_width + max_log2_ratio
) (
  input  logic                          aclk,
  input  logic                          resetn,
  input  logic [3:0]                    i4_log2_ratio,
  input  logic signed [inout_width-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic signed [inout_width-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
);

  localparam int         cnt_w     = max_log2_ratio;
  localparam logic [3:0] shift_lim = 4'(max_log2_ratio);
`ifdef ROUND_EN
  localparam logic signed [acc_width-1:0] pos_lim = acc_width'((2 ** (inout_width - 1)) - 1);
`endif

  function automatic logic signed [inout_width-1:0] scale(
    input logic signed [acc_width-1:0] sum,
    input logic [3:0]                  n
  );
    logic signed [acc_width-1:0] q;
`ifdef ROUND_EN
    logic signed [acc_width-1:0] r;
    r = sum;
    if (n != 4'd0) r = sum + (acc_width'(1) << (n - 4'd1));
    q = r >>> n;
    if (q > pos_lim) q = pos_lim;
`else
    q = sum >>> n;
`endif
    return q[inout_width-1:0];
  endfunction

  logic signed [acc_width-1:0]   acc_p0, sum_p0;
  logic [cnt_w-1:0]              cnt_p0, term_cnt;
  logic [3:0]                    shift_p0, shift_eff;
  logic                          tlast_p0, terminal, beat;
  logic                          vld_p0, last_p0;
  logic signed [inout_width-1:0] avg_p0;

  // The first beat of a block sees the live ratio; later beats use the latched one.
  assign shift_eff     = (cnt_p0 == '0) ? clamp_shift(i4_log2_ratio, shift_lim) : shift_p0;
  assign term_cnt      = ~({cnt_w{1'b1}} << shift_eff);
  assign terminal      = (cnt_p0 == term_cnt);
  assign s_axis_tready = !(terminal && m_axis_tvalid && !m_axis_tready);
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign sum_p0        = acc_p0 + acc_width'(s_axis_tdata);
  assign vld_p0        = beat && terminal;
  assign avg_p0        = scale(sum_p0, shift_eff);
  assign last_p0       = tlast_p0 | s_axis_tlast;

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      acc_p0   <= '0;
      cnt_p0   <= '0;
      tlast_p0 <= 1'b0;
      shift_p0 <= clamp_shift(i4_log2_ratio, shift_lim);
    end else if (beat) begin
      if (cnt_p0 == '0) shift_p0 <= shift_eff;
      if (terminal) begin
        acc_p0   <= '0;
        cnt_p0   <= '0;
        tlast_p0 <= 1'b0;
      end else begin
        acc_p0   <= sum_p0;
        cnt_p0   <= cnt_p0 + cnt_w'(1);
        tlast_p0 <= last_p0;
      end
    end
  end

  // Stage boundary: averaged result into the single-entry output register.
  axis_out_reg #(
    .width(inout_width)
  ) u_out (
    .aclk         (aclk),
    .resetn       (resetn),
    .ld           (vld_p0),
    .ld_data      (avg_p0),
    .ld_last      (last_p0),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

endmodule
